// File: rtl/car_sensor_pkg.sv
// car_sensor_pkg
// Shared types and constants for the parking-lot sensor stimulus generator.
//   mode_t        : requested sequence (enter, exit, balk-in, reserved)
//   state_t       : sequence FSM states
//   PAT_*         : 2-bit {outer, inner} sensor patterns
//   phase_pattern : maps an FSM state and a latched mode to its sensor pattern
package car_sensor_pkg;

    typedef enum logic [1:0] {
        ENTER = 2'b00,
        EXIT  = 2'b01,
        BALK  = 2'b10,
        RSVD  = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        IDLE,
        P1,
        P2,
        P3,
        GAP
    } state_t;

    localparam logic [1:0] PAT_CLEAR = 2'b00;
    localparam logic [1:0] PAT_OUTER = 2'b10;
    localparam logic [1:0] PAT_BOTH  = 2'b11;
    localparam logic [1:0] PAT_INNER = 2'b01;

    // P1 and P3 are the only phases whose pattern depends on direction; P2 is
    // always both-blocked, so every phase boundary is a single-bit change.
    function automatic logic [1:0] phase_pattern(input state_t s, input mode_t m);
        logic [1:0] pat;
        pat = PAT_CLEAR;
        case (s)
            P1:      pat = (m == EXIT)  ? PAT_INNER : PAT_OUTER;
            P2:      pat = PAT_BOTH;
            P3:      pat = (m == ENTER) ? PAT_INNER : PAT_OUTER;
            default: pat = PAT_CLEAR;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer
// Per-phase dwell counter. Counts 0..DWELL-1 and wraps on its own at the end
// of each phase, so phase boundaries restart it automatically.
//   clk    : system clock
//   reset  : synchronous active-high reset
//   clear  : hold the count at zero (used while the sequencer is idle)
//   expire : high on the last cycle of a phase
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expire
);

    localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [W-1:0] LAST = W'(DWELL - 1);

    logic [W-1:0] count;

    // With DWELL = 1 the wrap condition is always true, so the count is
    // pinned at zero and every cycle is a phase's last cycle.
    always_ff @(posedge clk) begin
        if (reset || clear || expire) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/car_sensor_driver.sv
// car_sensor_driver
// Replays the outer/inner sensor sequence a car produces at the lot gate.
// A start in IDLE latches the mode and runs P1 -> P2 -> P3 -> GAP, each held
// for DWELL cycles, followed by a one-cycle done pulse back in IDLE.
// Optional feature macro: PARKING_MODEL_EN (adds the occupancy counter/port).
//   clk       : system clock
//   reset     : synchronous active-high reset
//   start     : sequence request, sampled only in IDLE
//   mode      : 00 enter, 01 exit, 10 balk-in, 11 reserved (ignored)
//   outer     : outer sensor level, 1 = blocked
//   inner     : inner sensor level, 1 = blocked
//   busy      : high while a sequence is running
//   done      : one-cycle pulse when a sequence completes
//   occupancy : expected car count (PARKING_MODEL_EN only)
module car_sensor_driver
    import car_sensor_pkg::*;
#(
    parameter int DWELL    = 4,
    parameter int CAPACITY = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       outer,
    output logic       inner,
    output logic       busy,
    output logic       done
`ifdef PARKING_MODEL_EN
    ,
    output logic [4:0] occupancy
`endif
);

    state_t state;
    state_t state_next;
    mode_t  mode_q;
    mode_t  mode_next;
    logic   expire;
    logic   start_ok;
    logic   seq_end;

    // The occupancy counter is 5 bits wide, so the capacity must fit in it.
    if (CAPACITY < 0 || CAPACITY > 31) begin : g_capacity_out_of_range
    end

    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .expire (expire)
    );

    assign start_ok = (state == IDLE) && start && (mode != RSVD);
    assign seq_end  = (state == GAP) && expire;

    always_comb begin
        state_next = state;
        mode_next  = mode_q;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = P1;
                    mode_next  = mode_t'(mode);
                end
            end
            P1:      if (expire) state_next = P2;
            P2:      if (expire) state_next = P3;
            P3:      if (expire) state_next = GAP;
            GAP:     if (expire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so the P1 pattern and busy
    // appear at the same edge that accepts start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            mode_q         <= ENTER;
            {outer, inner} <= PAT_CLEAR;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_next;
            mode_q         <= mode_next;
            {outer, inner} <= phase_pattern(state_next, mode_next);
            busy           <= (state_next != IDLE);
            done           <= seq_end;
        end
    end

`ifdef PARKING_MODEL_EN
    // Updated on the same edge that raises done; a full lot ignores enters
    // and an empty lot ignores exits, while the sequence itself still runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= 5'd0;
        end else if (seq_end) begin
            if (mode_q == ENTER && occupancy < 5'(CAPACITY)) begin
                occupancy <= occupancy + 5'd1;
            end else if (mode_q == EXIT && occupancy != 5'd0) begin
                occupancy <= occupancy - 5'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_car_sensor_driver.sv
// tb_car_sensor_driver
// Self-checking bench for car_sensor_driver: a directed vector table for the
// enter sequence and ignored requests, hand-written corner sequences, and a
// randomized run compared against a sequence-level reference model. A DWELL=4
// and a DWELL=1 instance share the same stimulus.
module tb_car_sensor_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;

    logic o4, i4, b4, d4;
    logic o1, i1, b1, d1;
`ifdef PARKING_MODEL_EN
    logic [4:0] occ4, occ1;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    car_sensor_driver #(.DWELL(4), .CAPACITY(25)) dut4 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .outer (o4),
        .inner (i4),
        .busy  (b4),
        .done  (d4)
`ifdef PARKING_MODEL_EN
        ,
        .occupancy (occ4)
`endif
    );

    car_sensor_driver #(.DWELL(1), .CAPACITY(25)) dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .outer (o1),
        .inner (i1),
        .busy  (b1),
        .done  (d1)
`ifdef PARKING_MODEL_EN
        ,
        .occupancy (occ1)
`endif
    );

    // Reference model: a sequence is either running (with elapsed cycle count
    // t since acceptance) or not. The pattern is looked up from t / DWELL.
    typedef struct {
        bit active;
        int t;
        int m;
        bit done;
        int occ;
    } model_t;

    model_t m4;
    model_t m1;

    function automatic model_t model_step(model_t s, bit r, bit st, int md, int d, int cap);
        model_t n;
        n = s;
        n.done = 1'b0;
        if (r) begin
            n.active = 1'b0;
            n.t = 0;
            n.occ = 0;
        end else if (!s.active) begin
            if (st && md != 3) begin
                n.active = 1'b1;
                n.t = 0;
                n.m = md;
            end
        end else begin
            n.t = s.t + 1;
            if (n.t == 4 * d) begin
                n.active = 1'b0;
                n.done = 1'b1;
                if (s.m == 0 && s.occ < cap) n.occ = s.occ + 1;
                if (s.m == 1 && s.occ > 0)   n.occ = s.occ - 1;
            end
        end
        return n;
    endfunction

    function automatic int exp_pat(model_t s, int d);
        int seq [3][4];
        seq = '{'{2, 3, 1, 0}, '{1, 3, 2, 0}, '{2, 3, 2, 0}};
        if (!s.active) return 0;
        return seq[s.m][s.t / d];
    endfunction

    always @(posedge clk) begin
        m4 = model_step(m4, reset, start, int'(mode), 4, 25);
        m1 = model_step(m1, reset, start, int'(mode), 1, 25);
    end

    // Drives inputs away from the active edge, then returns just after it.
    task automatic applyStimulus(input bit r, input bit s, input logic [1:0] md);
        @(negedge clk);
        reset = r;
        start = s;
        mode  = md;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("d4 pattern", int'({o4, i4}), exp_pat(m4, 4));
        checkOutput("d4 busy",    int'(b4),       int'(m4.active));
        checkOutput("d4 done",    int'(d4),       int'(m4.done));
        checkOutput("d1 pattern", int'({o1, i1}), exp_pat(m1, 1));
        checkOutput("d1 busy",    int'(b1),       int'(m1.active));
        checkOutput("d1 done",    int'(d1),       int'(m1.done));
`ifdef PARKING_MODEL_EN
        checkOutput("d4 occupancy", int'(occ4), m4.occ);
        checkOutput("d1 occupancy", int'(occ1), m1.occ);
`endif
    endtask

    // One start pulse followed by the full 4*DWELL run, ending on the done cycle.
    task automatic runAndCheck(input logic [1:0] md);
        applyStimulus(1'b0, 1'b1, md);
        checkModel();
        repeat (16) begin
            applyStimulus(1'b0, 1'b0, md);
            checkModel();
        end
    endtask

    typedef struct {
        bit         r;
        bit         s;
        logic [1:0] m;
        logic [1:0] pat;
        bit         busy;
        bit         done;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, logic [1:0] m, logic [1:0] pat, bit b, bit d);
        vec_t v;
        v.r = r; v.s = s; v.m = m; v.pat = pat; v.busy = b; v.done = d;
        return v;
    endfunction

    vec_t table_v [21];

    initial begin
        int busy_cycles;
        int exp1 [4];

        reset = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        m4 = '{active: 0, t: 0, m: 0, done: 0, occ: 0};
        m1 = '{active: 0, t: 0, m: 0, done: 0, occ: 0};

        // Reset, reserved mode in IDLE, then an enter with a stray exit request
        // at cycle 6 that must be ignored.
        table_v[0]  = mk(1, 0, 2'b00, 2'b00, 0, 0);
        table_v[1]  = mk(0, 1, 2'b11, 2'b00, 0, 0);
        table_v[2]  = mk(0, 1, 2'b11, 2'b00, 0, 0);
        table_v[3]  = mk(0, 1, 2'b00, 2'b10, 1, 0);
        table_v[4]  = mk(0, 0, 2'b00, 2'b10, 1, 0);
        table_v[5]  = mk(0, 0, 2'b00, 2'b10, 1, 0);
        table_v[6]  = mk(0, 0, 2'b00, 2'b10, 1, 0);
        table_v[7]  = mk(0, 0, 2'b00, 2'b11, 1, 0);
        table_v[8]  = mk(0, 0, 2'b00, 2'b11, 1, 0);
        table_v[9]  = mk(0, 1, 2'b01, 2'b11, 1, 0);
        table_v[10] = mk(0, 0, 2'b00, 2'b11, 1, 0);
        table_v[11] = mk(0, 0, 2'b00, 2'b01, 1, 0);
        table_v[12] = mk(0, 0, 2'b00, 2'b01, 1, 0);
        table_v[13] = mk(0, 0, 2'b00, 2'b01, 1, 0);
        table_v[14] = mk(0, 0, 2'b00, 2'b01, 1, 0);
        table_v[15] = mk(0, 0, 2'b00, 2'b00, 1, 0);
        table_v[16] = mk(0, 0, 2'b00, 2'b00, 1, 0);
        table_v[17] = mk(0, 0, 2'b00, 2'b00, 1, 0);
        table_v[18] = mk(0, 0, 2'b00, 2'b00, 1, 0);
        table_v[19] = mk(0, 0, 2'b00, 2'b00, 0, 1);
        table_v[20] = mk(0, 0, 2'b00, 2'b00, 0, 0);

        for (int k = 0; k < 21; k++) begin
            applyStimulus(table_v[k].r, table_v[k].s, table_v[k].m);
            checkOutput($sformatf("table[%0d] pattern", k), int'({o4, i4}), int'(table_v[k].pat));
            checkOutput($sformatf("table[%0d] busy", k),    int'(b4),       int'(table_v[k].busy));
            checkOutput($sformatf("table[%0d] done", k),    int'(d4),       int'(table_v[k].done));
        end

        $display("[TB] exit and balk-in sequences");
        runAndCheck(2'b01);
        checkOutput("exit done at 16", int'(d4), 1);
        runAndCheck(2'b10);
        checkOutput("balk done at 16", int'(d4), 1);
        applyStimulus(1'b0, 1'b0, 2'b00);
        checkModel();

        $display("[TB] reset mid-sequence");
        applyStimulus(1'b0, 1'b1, 2'b00);
        repeat (8) applyStimulus(1'b0, 1'b0, 2'b00);
        checkOutput("pre-reset pattern", int'({o4, i4}), 1);
        applyStimulus(1'b1, 1'b0, 2'b00);
        checkOutput("reset pattern", int'({o4, i4}), 0);
        checkOutput("reset busy",    int'(b4),       0);
        checkOutput("reset done",    int'(d4),       0);
        applyStimulus(1'b0, 1'b0, 2'b00);
        checkOutput("post-reset done", int'(d4), 0);
        checkOutput("post-reset busy", int'(b4), 0);
        busy_cycles = 0;
        applyStimulus(1'b0, 1'b1, 2'b00);
        checkModel();
        if (b4) busy_cycles++;
        repeat (16) begin
            applyStimulus(1'b0, 1'b0, 2'b00);
            checkModel();
            if (b4) busy_cycles++;
        end
        checkOutput("busy cycle count", busy_cycles, 16);

        $display("[TB] DWELL=1 instance");
        applyStimulus(1'b1, 1'b0, 2'b00);
        exp1 = '{2, 3, 1, 0};
        applyStimulus(1'b0, 1'b1, 2'b00);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) applyStimulus(1'b0, 1'b0, 2'b00);
            checkOutput($sformatf("dwell1 cycle %0d pattern", c), int'({o1, i1}), exp1[c]);
            checkOutput($sformatf("dwell1 cycle %0d busy", c),    int'(b1),       1);
        end
        applyStimulus(1'b0, 1'b0, 2'b00);
        checkOutput("dwell1 done at 4", int'(d1), 1);
        checkOutput("dwell1 busy at 4", int'(b1), 0);

        $display("[TB] start held high");
        applyStimulus(1'b1, 1'b0, 2'b00);
        for (int c = 0; c < 80; c++) begin
            applyStimulus(1'b0, 1'b1, 2'(c / 17 % 3));
            checkModel();
        end

`ifdef PARKING_MODEL_EN
        $display("[TB] occupancy model");
        applyStimulus(1'b1, 1'b0, 2'b00);
        runAndCheck(2'b00);
        runAndCheck(2'b00);
        runAndCheck(2'b10);
        checkOutput("occ after 2 enters + balk", int'(occ4), 2);
        runAndCheck(2'b01);
        checkOutput("occ after exit 1", int'(occ4), 1);
        runAndCheck(2'b01);
        checkOutput("occ after exit 2", int'(occ4), 0);
        runAndCheck(2'b01);
        checkOutput("occ after exit 3", int'(occ4), 0);
        applyStimulus(1'b1, 1'b0, 2'b00);
        repeat (26) runAndCheck(2'b00);
        checkOutput("occ after 26 enters", int'(occ4), 25);
`endif

        $display("[TB] randomized run");
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                          2'($urandom_range(0, 3)));
            checkModel();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
